// File: rtl/lvdc_timing_gen.sv
// LVDC timing generator: phase / bit-time / word-time sequencer with a halt and single-step handshake.
// Define LVDC_TMR_EN to triplicate the counters and FSM state with per-bit 2-of-3 voting.
module lvdc_timing_gen #(
  parameter  int NPH  = 3,
  parameter  int NBIT = 14,
  parameter  int NWT  = 4,
  localparam int BTW  = (NBIT > 1) ? $clog2(NBIT) : 1,
  localparam int WTW  = (NWT > 1) ? $clog2(NWT) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic           halt_req_i,
  input  logic           step_i,
  output logic [NPH-1:0] ph_o,
  output logic [NPH-1:0] phn_o,
  output logic [BTW-1:0] bt_o,
  output logic [WTW-1:0] wt_o,
  output logic           bt_last_o,
  output logic           sync_o,
  output logic           halt_ack_o,
  output logic           tmr_err_o
);

  localparam int PCW = (NPH > 1) ? $clog2(NPH) : 1;
  localparam int TW  = 2 + WTW + BTW + PCW;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2,
    S_STEP  = 2'd3
  } state_e;

  // Whole timing state packed as {state, wt, bt, pc}; all-zero is the reset image.
  logic [TW-1:0]  tm_v;
  logic [TW-1:0]  tm_d;
  state_e         st_v, st_d;
  logic [WTW-1:0] wt_v, wt_d;
  logic [BTW-1:0] bt_v, bt_d;
  logic [PCW-1:0] pc_v, pc_d;
  logic           adv;
  logic           wte;

  assign st_v = state_e'(tm_v[TW-1 -: 2]);
  assign wt_v = tm_v[PCW+BTW +: WTW];
  assign bt_v = tm_v[PCW +: BTW];
  assign pc_v = tm_v[PCW-1:0];
  assign tm_d = {st_d, wt_d, bt_d, pc_d};

  assign adv = rst_ni && en_i && (st_v != S_HALT);
  assign wte = adv && (pc_v == PCW'(NPH - 1)) && (bt_v == BTW'(NBIT - 1));

  always_comb begin
    pc_d = pc_v;
    bt_d = bt_v;
    wt_d = wt_v;
    if (adv) begin
      if (pc_v == PCW'(NPH - 1)) begin
        pc_d = '0;
        if (bt_v == BTW'(NBIT - 1)) begin
          bt_d = '0;
          wt_d = (wt_v == WTW'(NWT - 1)) ? '0 : wt_v + 1'b1;
        end else begin
          bt_d = bt_v + 1'b1;
        end
      end else begin
        pc_d = pc_v + 1'b1;
      end
    end
  end

  // halt_req is a level and is honoured even while en_i is low; step only counts on an enabled clock.
  always_comb begin
    st_d = st_v;
    case (st_v)
      S_RUN: begin
        if (halt_req_i) st_d = wte ? S_HALT : S_DRAIN;
      end
      S_DRAIN: begin
        if (!halt_req_i) st_d = S_RUN;
        else if (wte)    st_d = S_HALT;
      end
      S_HALT: begin
        if (!halt_req_i)        st_d = S_RUN;
        else if (step_i && en_i) st_d = S_STEP;
      end
      S_STEP: begin
        if (wte) st_d = S_HALT;
      end
      default: st_d = S_RUN;
    endcase
  end

`ifdef LVDC_TMR_EN
  logic [TW-1:0] tm_q [3];

  assign tm_v = (tm_q[0] & tm_q[1]) | (tm_q[0] & tm_q[2]) | (tm_q[1] & tm_q[2]);

  // Every copy reloads from the voted next state, so a single upset is scrubbed on the next clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) tm_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) tm_q[i] <= tm_d;
    end
  end

  assign tmr_err_o = (tm_q[0] != tm_v) || (tm_q[1] != tm_v) || (tm_q[2] != tm_v);
`else
  logic [TW-1:0] tm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tm_q <= '0;
    else         tm_q <= tm_d;
  end

  assign tm_v      = tm_q;
  assign tmr_err_o = 1'b0;
`endif

  always_comb begin
    ph_o = '0;
    if (adv) ph_o = NPH'(1) << pc_v;
  end

  assign phn_o      = ~ph_o;
  assign bt_o       = bt_v;
  assign wt_o       = wt_v;
  assign bt_last_o  = (bt_v == BTW'(NBIT - 1));
  assign sync_o     = ph_o[0] && (bt_v == '0) && (wt_v == '0);
  assign halt_ack_o = (st_v == S_HALT);

endmodule

// File: tb/tb_lvdc_timing_gen.sv
// Self-checking bench for lvdc_timing_gen: default-parameter instance driven against a tick-count
// reference model, plus a small NPH=4/NBIT=2/NWT=3 instance for the alternate configuration.
module tb_lvdc_timing_gen;

  localparam int NPH = 3, NBIT = 14, NWT = 4;
  localparam int WPC = NPH * NBIT;
  localparam int CYC = WPC * NWT;
  localparam int NPH4 = 4, NBIT4 = 2, NWT4 = 3;
  localparam int CYC4 = NPH4 * NBIT4 * NWT4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_STEP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, halt_req = 1'b0, step = 1'b0;
  logic en4 = 1'b0;

  logic [NPH-1:0] ph, phn;
  logic [3:0]     bt;
  logic [1:0]     wt;
  logic           bt_last, sync, halt_ack, tmr_err;

  logic [NPH4-1:0] ph4, phn4;
  logic [0:0]      bt4;
  logic [1:0]      wt4;
  logic            bt_last4, sync4, halt_ack4, tmr_err4;

  lvdc_timing_gen #(.NPH(NPH), .NBIT(NBIT), .NWT(NWT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .halt_req_i(halt_req), .step_i(step),
    .ph_o(ph), .phn_o(phn), .bt_o(bt), .wt_o(wt), .bt_last_o(bt_last),
    .sync_o(sync), .halt_ack_o(halt_ack), .tmr_err_o(tmr_err)
  );

  lvdc_timing_gen #(.NPH(NPH4), .NBIT(NBIT4), .NWT(NWT4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en4), .halt_req_i(1'b0), .step_i(1'b0),
    .ph_o(ph4), .phn_o(phn4), .bt_o(bt4), .wt_o(wt4), .bt_last_o(bt_last4),
    .sync_o(sync4), .halt_ack_o(halt_ack4), .tmr_err_o(tmr_err4)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model: t counts advancing clocks within one computer cycle; indices follow by division.
  int t = 0, mode = M_RUN, t4 = 0;

  function automatic logic m_adv();
    return en && (mode != M_HALT);
  endfunction

  function automatic logic [NPH-1:0] x_ph();
    logic [NPH-1:0] v;
    v = '0;
    if (m_adv()) v[t % NPH] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] x_bt();
    return 4'((t / NPH) % NBIT);
  endfunction

  function automatic logic [1:0] x_wt();
    return 2'((t / WPC) % NWT);
  endfunction

  function automatic logic x_sync();
    return m_adv() && (t == 0);
  endfunction

  function automatic logic [NPH4-1:0] x_ph4();
    logic [NPH4-1:0] v;
    v = '0;
    if (en4) v[t4 % NPH4] = 1'b1;
    return v;
  endfunction

  task automatic m_update();
    logic a, word_end;
    a        = m_adv();
    word_end = a && (((t + 1) % WPC) == 0);
    case (mode)
      M_RUN:   if (halt_req) mode = word_end ? M_HALT : M_DRAIN;
      M_DRAIN: if (!halt_req) mode = M_RUN; else if (word_end) mode = M_HALT;
      M_HALT:  if (!halt_req) mode = M_RUN; else if (step && en) mode = M_STEP;
      default: if (word_end) mode = M_HALT;
    endcase
    if (a) t = (t + 1) % CYC;
    if (en4) t4 = (t4 + 1) % CYC4;
  endtask

  task automatic m_reset();
    t = 0; mode = M_RUN; t4 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; halt_req = 1'b0; step = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_chk++; if (ph !== '0 || phn !== '1) begin n_fail++; $display("FAIL reset_ph ph=%b phn=%b want 000/111", ph, phn); end
    n_chk++; if (bt !== 4'd0 || wt !== 2'd0) begin n_fail++; $display("FAIL reset_idx bt=%0d wt=%0d want 0/0", bt, wt); end
    n_chk++; if (bt_last !== 1'b0 || sync !== 1'b0) begin n_fail++; $display("FAIL reset_flags bt_last=%b sync=%b want 0/0", bt_last, sync); end
    n_chk++; if (halt_ack !== 1'b0 || tmr_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack halt_ack=%b tmr_err=%b want 0/0", halt_ack, tmr_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    int first_bl, n_sync, last_sync;
    first_bl = -1; n_sync = 0; last_sync = -1;
    for (int i = 0; i < CYC + 3; i++) begin
      #1;
      n_chk++; if (ph !== x_ph() || phn !== ~x_ph()) begin n_fail++; $display("FAIL run_ph clk=%0d ph=%b want %b", i, ph, x_ph()); end
      n_chk++; if (bt !== x_bt() || wt !== x_wt()) begin n_fail++; $display("FAIL run_idx clk=%0d bt=%0d wt=%0d want %0d/%0d", i, bt, wt, x_bt(), x_wt()); end
      n_chk++; if (sync !== x_sync() || bt_last !== (x_bt() == 4'(NBIT - 1))) begin n_fail++; $display("FAIL run_flags clk=%0d sync=%b bt_last=%b", i, sync, bt_last); end
      if (i == 3) begin
        n_chk++; if (bt !== 4'd1) begin n_fail++; $display("FAIL run_bt_clk3 bt=%0d want 1", bt); end
      end
      if (bt_last && first_bl < 0) first_bl = i;
      if (sync) begin n_sync++; last_sync = i; end
      tick();
    end
    n_chk++; if (first_bl != 39) begin n_fail++; $display("FAIL run_bt_last_first got=%0d want 39", first_bl); end
    n_chk++; if (n_sync != 2 || last_sync != CYC) begin n_fail++; $display("FAIL run_sync count=%0d last=%0d want 2/%0d", n_sync, last_sync, CYC); end
  endtask

  task automatic test_halt();
    int k;
    k = 0;
    en = 1'b1; halt_req = 1'b0;
    while (t != 2 * WPC + 5 * NPH && k < 400) begin tick(); k++; end
    halt_req = 1'b1;
    for (k = 0; k < 60; k++) begin
      #1;
      n_chk++; if (ph !== x_ph() || halt_ack !== (mode == M_HALT)) begin n_fail++; $display("FAIL drain k=%0d ph=%b ack=%b want %b/%b", k, ph, halt_ack, x_ph(), mode == M_HALT); end
      if (halt_ack) break;
      tick();
    end
    n_chk++; if (k != 27) begin n_fail++; $display("FAIL halt_latency got=%0d want 27", k); end
    n_chk++; if (ph !== '0 || wt !== 2'd3 || bt !== 4'd0) begin n_fail++; $display("FAIL halt_pos ph=%b wt=%0d bt=%0d want 0/3/0", ph, wt, bt); end
  endtask

  task automatic test_step();
    int pulses, k;
    logic first_sync;
    for (int s = 0; s < 2; s++) begin
      step = 1'b1;
      #1;
      n_chk++; if (ph !== '0 || halt_ack !== 1'b1) begin n_fail++; $display("FAIL step_pre s=%0d ph=%b ack=%b want 0/1", s, ph, halt_ack); end
      tick();
      pulses = 0; first_sync = 1'b0;
      for (k = 0; k < 100; k++) begin
        step = (mode == M_STEP) ? 1'($urandom % 2) : 1'b0;
        #1;
        n_chk++; if (ph !== x_ph() || sync !== x_sync()) begin n_fail++; $display("FAIL step_run s=%0d k=%0d ph=%b sync=%b want %b/%b", s, k, ph, sync, x_ph(), x_sync()); end
        if (k == 0) first_sync = sync;
        if (ph != '0) pulses++;
        if (halt_ack) break;
        tick();
      end
      step = 1'b0;
      n_chk++; if (pulses != WPC) begin n_fail++; $display("FAIL step_pulses s=%0d got=%0d want %0d", s, pulses, WPC); end
      n_chk++; if (wt !== 2'(s) || first_sync !== (s == 1)) begin n_fail++; $display("FAIL step_end s=%0d wt=%0d first_sync=%b want %0d/%b", s, wt, first_sync, s, s == 1); end
    end
  endtask

  task automatic test_release_with_step();
    step = 1'b1; halt_req = 1'b0;
    #1;
    n_chk++; if (halt_ack !== 1'b1 || ph !== '0) begin n_fail++; $display("FAIL rel_pre ack=%b ph=%b want 1/0", halt_ack, ph); end
    tick();
    step = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_chk++; if (halt_ack !== 1'b0 || ph === '0 || ph !== x_ph()) begin n_fail++; $display("FAIL rel_run k=%0d ack=%b ph=%b want 0/%b", k, halt_ack, ph, x_ph()); end
      tick();
    end
  endtask

  task automatic test_small_cfg();
    en4 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      en4 = !(i >= 10 && i < 15);
      #1;
      n_chk++; if (ph4 !== x_ph4() || phn4 !== ~x_ph4()) begin n_fail++; $display("FAIL cfg4_ph i=%0d ph=%b want %b", i, ph4, x_ph4()); end
      n_chk++; if (bt4 !== 1'((t4 / NPH4) % NBIT4) || wt4 !== 2'(t4 / (NPH4 * NBIT4))) begin n_fail++; $display("FAIL cfg4_idx i=%0d bt=%0d wt=%0d", i, bt4, wt4); end
      n_chk++; if (sync4 !== (en4 && t4 == 0) || halt_ack4 !== 1'b0) begin n_fail++; $display("FAIL cfg4_sync i=%0d sync=%b ack=%b", i, sync4, halt_ack4); end
      tick();
    end
    en4 = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom % 8) != 0;
      if ($urandom % 40 == 0) halt_req = ~halt_req;
      step = ($urandom % 6) == 0;
      #1;
      n_chk++; if (ph !== x_ph() || phn !== ~x_ph()) begin n_fail++; $display("FAIL rnd_ph i=%0d ph=%b want %b", i, ph, x_ph()); end
      n_chk++; if (bt !== x_bt() || wt !== x_wt()) begin n_fail++; $display("FAIL rnd_idx i=%0d bt=%0d wt=%0d want %0d/%0d", i, bt, wt, x_bt(), x_wt()); end
      n_chk++; if (sync !== x_sync() || halt_ack !== (mode == M_HALT)) begin n_fail++; $display("FAIL rnd_flags i=%0d sync=%b ack=%b want %b/%b", i, sync, halt_ack, x_sync(), mode == M_HALT); end
      n_chk++; if (tmr_err !== 1'b0) begin n_fail++; $display("FAIL rnd_tmr i=%0d tmr_err=%b want 0", i, tmr_err); end
      tick();
    end
    step = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    en = 1'b1; halt_req = 1'b0; step = 1'b0;
    for (k = 0; k < 4; k++) tick();
    halt_req = 1'b1;
    k = 0;
    while (mode != M_DRAIN && k < 60) begin tick(); k++; end
    tick();
    #1;
    n_chk++; if (ph !== x_ph() || halt_ack !== (mode == M_HALT)) begin n_fail++; $display("FAIL pre_rst ph=%b ack=%b want %b/%b", ph, halt_ack, x_ph(), mode == M_HALT); end
    rst_n = 1'b0;
    m_reset();
    #1;
    n_chk++; if (ph !== '0 || phn !== '1 || sync !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ph ph=%b phn=%b sync=%b want 0/1/0", ph, phn, sync); end
    n_chk++; if (bt !== 4'd0 || wt !== 2'd0 || halt_ack !== 1'b0 || bt_last !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state bt=%0d wt=%0d ack=%b bt_last=%b want 0", bt, wt, halt_ack, bt_last); end
    tick();
    rst_n = 1'b1; halt_req = 1'b0;
    #1;
    n_chk++; if (ph !== 3'b001 || sync !== 1'b1 || halt_ack !== 1'b0) begin n_fail++; $display("FAIL restart ph=%b sync=%b ack=%b want 001/1/0", ph, sync, halt_ack); end
    tick();
    #1;
    n_chk++; if (ph !== 3'b010) begin n_fail++; $display("FAIL restart_seq ph=%b want 010", ph); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_halt();
    test_step();
    test_release_with_step();
    test_small_cfg();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
